// File: rtl/apb_pkg.sv
// Shared APB definitions for the slave register bank.
// FSM encoding, bus widths, slot map and error pattern.
package apb_pkg;

    localparam int APB_DW   = 32;
    localparam int APB_AW   = 32;
    localparam int NUM_PSEL = 3;

    localparam logic [APB_AW-1:0] SLOT0_BASE = 32'h0000_0000;
    localparam logic [APB_AW-1:0] SLOT1_BASE = 32'h8400_0000;
    localparam logic [APB_AW-1:0] SLOT2_BASE = 32'h8800_0000;
    localparam logic [APB_AW-1:0] MAP_END    = 32'h8C00_0000;

    localparam logic [APB_DW-1:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic {
        IDLE,
        ACCESS
    } apb_state_t;

endpackage

// File: rtl/apb_slave_regbank_if.sv
// APB bus between the bridge (master) and a slave.
// Carries selects, address/data and the ready/error response.
interface apb_slave_regbank_if;
    import apb_pkg::*;

    logic [NUM_PSEL-1:0] psel;
    logic                penable;
    logic                pwrite;
    logic [APB_AW-1:0]   paddr;
    logic [APB_DW-1:0]   pwdata;
    logic [APB_DW-1:0]   pr_data;
    logic                pready;
    logic                pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pr_data, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pr_data, pready, pslverr
    );

endinterface

// File: rtl/apb_reg_array.sv
// DEPTH x 32 register storage with synchronous clear,
// one write port and one combinational read port.
module apb_reg_array
    import apb_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [IW-1:0]     waddr,
    input  logic [APB_DW-1:0] wdata,
    input  logic [IW-1:0]     raddr,
    output logic [APB_DW-1:0] rdata
);

    logic [APB_DW-1:0] mem [DEPTH];

    // Clear has priority over the write port.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_regbank.sv
// APB slave register bank with programmable wait states
// and error response on unmapped or misaligned addresses.
module apb_slave_regbank
    import apb_pkg::*;
#(
    parameter int               SEL_IDX     = 0,
    parameter logic [APB_AW-1:0] BASE_ADDR  = 32'h0000_0000,
    parameter int               DEPTH       = 16,
    parameter int               WAIT_STATES = 0
) (
    input  logic               hclk,
    input  logic               hreset,
    apb_slave_regbank_if.slave bus
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [APB_AW-1:0] SPAN = APB_AW'(DEPTH * 4);

    apb_state_t        state;
    apb_state_t        state_n;
    logic [3:0]        cnt;
    logic [3:0]        cnt_n;
    logic              hit_q;
    logic              wr_q;
    logic [IW-1:0]     idx_q;
    logic [APB_DW-1:0] wdata_q;
    logic [APB_DW-1:0] rdata_q;
    logic [APB_DW-1:0] rdata_n;
    logic              latch;
    logic              we;

    logic              sel;
    logic [APB_AW-1:0] off;
    logic              hit_in;
    logic [IW-1:0]     idx_in;
    logic [APB_DW-1:0] arr_rd;

    assign sel    = bus.psel[SEL_IDX];
    assign off    = bus.paddr - BASE_ADDR;
    assign hit_in = (off < SPAN) && (bus.paddr[1:0] == 2'b00);
    assign idx_in = off[IW+1:2];

    apb_reg_array #(.DEPTH(DEPTH)) u_arr (
        .clk   (hclk),
        .clr   (hreset),
        .we    (we),
        .waddr (idx_q),
        .wdata (wdata_q),
        .raddr (idx_in),
        .rdata (arr_rd)
    );

    // Next-state, counter and read-data selection.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rdata_n = rdata_q;
        latch   = 1'b0;
        we      = 1'b0;
        unique case (state)
            IDLE: begin
                if (sel && !bus.penable) begin
                    state_n = ACCESS;
                    latch   = 1'b1;
                    cnt_n   = 4'(WAIT_STATES);
                    if (bus.pwrite) begin
                        rdata_n = '0;
                    end else begin
                        rdata_n = hit_in ? arr_rd : ERR_DATA;
                    end
                end
            end
            ACCESS: begin
                if (sel && bus.penable) begin
                    if (cnt != 4'd0) begin
                        cnt_n = cnt - 4'd1;
                    end else begin
                        state_n = IDLE;
                        we      = wr_q && hit_q;
                        rdata_n = '0;
                    end
                end else begin
                    state_n = IDLE;
                    rdata_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
                rdata_n = '0;
            end
        endcase
    end

    // State, counter and setup-phase latches.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state   <= IDLE;
            cnt     <= '0;
            hit_q   <= 1'b0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            rdata_q <= rdata_n;
            if (latch) begin
                hit_q   <= hit_in;
                wr_q    <= bus.pwrite;
                idx_q   <= idx_in;
                wdata_q <= bus.pwdata;
            end
        end
    end

    assign bus.pr_data = rdata_q;
    assign bus.pready  = (state == ACCESS) && (cnt == 4'd0);
    assign bus.pslverr = bus.pready && !hit_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Self-checking bench: three slaves on one APB bus,
// directed steps plus random traffic against a reference model.
module tb_apb_slave_regbank;
    import apb_pkg::*;

    logic        hclk;
    logic        hreset;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;

    int checks;
    int failures;

    logic [31:0] mem [3][16];
    logic [31:0] base [3];
    int          ws [3];

    apb_slave_regbank_if b0 ();
    apb_slave_regbank_if b1 ();
    apb_slave_regbank_if b2 ();

    assign b0.psel = psel;
    assign b0.penable = penable;
    assign b0.pwrite = pwrite;
    assign b0.paddr = paddr;
    assign b0.pwdata = pwdata;
    assign b1.psel = psel;
    assign b1.penable = penable;
    assign b1.pwrite = pwrite;
    assign b1.paddr = paddr;
    assign b1.pwdata = pwdata;
    assign b2.psel = psel;
    assign b2.penable = penable;
    assign b2.pwrite = pwrite;
    assign b2.paddr = paddr;
    assign b2.pwdata = pwdata;

    apb_slave_regbank #(
        .SEL_IDX(0), .BASE_ADDR(SLOT0_BASE),
        .DEPTH(16), .WAIT_STATES(0)
    ) u0 (.hclk(hclk), .hreset(hreset), .bus(b0.slave));

    apb_slave_regbank #(
        .SEL_IDX(1), .BASE_ADDR(SLOT0_BASE),
        .DEPTH(16), .WAIT_STATES(2)
    ) u1 (.hclk(hclk), .hreset(hreset), .bus(b1.slave));

    apb_slave_regbank #(
        .SEL_IDX(2), .BASE_ADDR(SLOT2_BASE),
        .DEPTH(16), .WAIT_STATES(3)
    ) u2 (.hclk(hclk), .hreset(hreset), .bus(b2.slave));

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    function automatic logic [31:0] rd_of(int d);
        case (d)
            0: return b0.pr_data;
            1: return b1.pr_data;
            default: return b2.pr_data;
        endcase
    endfunction

    function automatic logic rdy_of(int d);
        case (d)
            0: return b0.pready;
            1: return b1.pready;
            default: return b2.pready;
        endcase
    endfunction

    function automatic logic err_of(int d);
        case (d)
            0: return b0.pslverr;
            1: return b1.pslverr;
            default: return b2.pslverr;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs,
                       logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 16; i++)
                mem[d][i] = 32'h0;
    endtask

    function automatic bit model_hit(int d, logic [31:0] a);
        logic [31:0] off;
        off = a - base[d];
        return (off < 32'd64) && (a % 4 == 0);
    endfunction

    function automatic int model_idx(int d, logic [31:0] a);
        logic [31:0] off;
        off = a - base[d];
        return int'(off / 4);
    endfunction

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic go_idle();
        psel = 3'b000;
        penable = 1'b0;
        step();
    endtask

    // One full APB transfer; bus is left in the access phase
    // so a following call gives back-to-back traffic.
    task automatic xfer(int d, bit wr, logic [31:0] a,
                        logic [31:0] wd, string tag);
        bit          hit;
        logic [31:0] exp_rd;
        int          waits;
        bit          done;
        hit = model_hit(d, a);
        if (wr)
            exp_rd = 32'h0;
        else if (hit)
            exp_rd = mem[d][model_idx(d, a)];
        else
            exp_rd = ERR_DATA;
        psel = 3'(1 << d);
        penable = 1'b0;
        pwrite = wr;
        paddr = a;
        pwdata = wd;
        step();
        penable = 1'b1;
        waits = 0;
        done = 0;
        while (!done) begin
            @(negedge hclk);
            chk({tag, ".rdata"}, rd_of(d), exp_rd);
            if (rdy_of(d)) begin
                done = 1;
            end else begin
                chk({tag, ".err_wait"}, 32'(err_of(d)), 32'h0);
                waits++;
                if (waits > 20) begin
                    chk({tag, ".timeout"}, 32'(waits), 32'(ws[d]));
                    done = 1;
                end
            end
        end
        chk({tag, ".waits"}, 32'(waits), 32'(ws[d]));
        chk({tag, ".slverr"}, 32'(err_of(d)), 32'(!hit));
        step();
        if (wr && hit)
            mem[d][model_idx(d, a)] = wd;
        chk({tag, ".post_ready"}, 32'(rdy_of(d)), 32'h0);
        chk({tag, ".post_rdata"}, rd_of(d), 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        int          d;
        int          k;
        checks = 0;
        failures = 0;
        base[0] = SLOT0_BASE;
        base[1] = SLOT0_BASE;
        base[2] = SLOT2_BASE;
        ws[0] = 0;
        ws[1] = 2;
        ws[2] = 3;
        model_clear();

        hreset = 1'b1;
        psel = 3'($urandom);
        penable = 1'($urandom);
        pwrite = 1'($urandom);
        paddr = $urandom;
        pwdata = $urandom;
        step();
        psel = 3'($urandom);
        penable = 1'($urandom);
        paddr = $urandom;
        step();
        @(negedge hclk);
        for (int i = 0; i < 3; i++) begin
            chk("reset.rdata", rd_of(i), 32'h0);
            chk("reset.ready", 32'(rdy_of(i)), 32'h0);
            chk("reset.err", 32'(err_of(i)), 32'h0);
        end
        hreset = 1'b0;
        go_idle();
        for (int i = 0; i < 16; i++)
            xfer(0, 0, 32'(i * 4), 32'h0, "reset_rd");

        go_idle();
        xfer(0, 1, 32'h8, 32'hA5A5_0001, "ws0_wr");
        xfer(0, 0, 32'h8, 32'h0, "ws0_rd");

        go_idle();
        xfer(1, 1, 32'h8, 32'h1234_5678, "ws2_wr");
        xfer(1, 0, 32'h8, 32'h0, "ws2_rd");

        go_idle();
        xfer(0, 1, 32'h40, 32'hFFFF_FFFF, "miss_wr");
        xfer(0, 0, 32'h40, 32'h0, "miss_rd");
        xfer(0, 0, 32'h6, 32'h0, "misalign_rd");
        xfer(0, 1, 32'h6, 32'h0BAD_0BAD, "misalign_wr");
        xfer(0, 0, 32'h4, 32'h0, "misalign_chk");
        for (int i = 0; i < 16; i++)
            xfer(0, 0, 32'(i * 4), 32'h0, "miss_bank");

        go_idle();
        xfer(0, 1, 32'h0, 32'h1, "b2b_w0");
        xfer(0, 1, 32'h4, 32'h2, "b2b_w1");
        psel = 3'b010;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 32'h0;
        pwdata = 32'hCAFE_F00D;
        step();
        @(negedge hclk);
        chk("pulse.ready", 32'(rdy_of(0)), 32'h0);
        chk("pulse.rdata", rd_of(0), 32'h0);
        xfer(0, 0, 32'h0, 32'h0, "b2b_r0");
        xfer(0, 0, 32'h4, 32'h0, "b2b_r1");
        xfer(1, 0, 32'h0, 32'h0, "pulse_nowr");

        go_idle();
        xfer(2, 1, SLOT2_BASE + 32'hC, 32'h1111_2222, "ab_pre");
        psel = 3'b100;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = SLOT2_BASE + 32'hC;
        pwdata = 32'h3333_4444;
        step();
        penable = 1'b1;
        step();
        penable = 1'b0;
        step();
        psel = 3'b000;
        @(negedge hclk);
        chk("abort.ready", 32'(rdy_of(2)), 32'h0);
        chk("abort.rdata", rd_of(2), 32'h0);
        step();
        xfer(2, 0, SLOT2_BASE + 32'hC, 32'h0, "abort_rd");

        go_idle();
        xfer(0, 1, 32'h10, 32'h5555_6666, "rst_pre");
        psel = 3'b001;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 32'h10;
        pwdata = 32'h7777_8888;
        step();
        penable = 1'b1;
        hreset = 1'b1;
        step();
        hreset = 1'b0;
        psel = 3'b000;
        penable = 1'b0;
        model_clear();
        @(negedge hclk);
        chk("rstab.ready", 32'(rdy_of(0)), 32'h0);
        chk("rstab.rdata", rd_of(0), 32'h0);
        step();
        xfer(0, 0, 32'h10, 32'h0, "rstab_rd");

        for (int n = 0; n < 60; n++) begin
            d = int'($urandom_range(0, 2));
            k = int'($urandom_range(0, 9));
            if (k < 7)
                a = base[d] + 32'($urandom_range(0, 15) * 4);
            else if (k < 9)
                a = base[d] + 32'h40 + 32'($urandom_range(0, 63) * 4);
            else
                a = base[d] + 32'($urandom_range(0, 63));
            wd = $urandom;
            xfer(d, 1'($urandom), a, wd, "rand");
            if ($urandom_range(0, 3) == 0)
                go_idle();
        end

        go_idle();
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
